// File: rtl/product_accumulator.sv
// Sums a programmed number of 17-bit multiplier products into a wide accumulator.
// Latency: the result is visible the cycle after the last accepted beat.
// Backpressure: products are taken only in ACCUM; the result is held until out_ready.
module product_accumulator #(
    parameter int ACC_W = 24,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic [15:0]      prod_in,
    input  logic             prod_cout,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overflow,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // One guard bit above the wider of accumulator and product, so the
    // wrap is visible even when ACC_W is narrower than a product.
    localparam int SUM_W = ((ACC_W > 17) ? ACC_W : 17) + 1;

    state_t           state_q;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_out_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] len_q;
    logic             out_valid_q;
    logic             overflow_q;
    logic             busy_q;

    logic [SUM_W-1:0] sum_d;
    logic [ACC_W-1:0] acc_d;
    logic             carry_d;
    logic             beat;
    logic             last_beat;

    always_comb begin
        sum_d   = SUM_W'(acc_q) + SUM_W'({prod_cout, prod_in});
        acc_d   = sum_d[ACC_W-1:0];
        carry_d = |sum_d[SUM_W-1:ACC_W];
    end

    assign in_ready  = (state_q == ACCUM);
    assign beat      = in_valid & in_ready;
    assign last_beat = beat && (cnt_q == (len_q - CNT_W'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            acc_out_q   <= '0;
            cnt_q       <= '0;
            len_q       <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        acc_q      <= '0;
                        overflow_q <= 1'b0;
                        busy_q     <= 1'b1;
                        if (len != '0) begin
                            len_q   <= len;
                            cnt_q   <= '0;
                            state_q <= ACCUM;
                        end else begin
                            // Empty sum: straight to a zero result, no beats taken.
                            acc_out_q   <= '0;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end
                    end
                end
                ACCUM: begin
                    if (beat) begin
                        acc_q      <= acc_d;
                        overflow_q <= overflow_q | carry_d;
                        cnt_q      <= cnt_q + CNT_W'(1);
                        if (last_beat) begin
                            acc_out_q   <= acc_d;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign acc_out   = acc_out_q;
    assign out_valid = out_valid_q;
    assign overflow  = overflow_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: vector table, hand sequences for the
// multi-cycle corners, and random sums against an arithmetic reference.
module tb_product_accumulator;

    typedef int unsigned uq_t[$];

    typedef struct {
        string       tag;
        int          len;
        int unsigned p[4];
        int          maxb;
        logic [23:0] e24;
        logic        ov24;
        logic [15:0] e16;
        logic        ov16;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  len;
    logic [15:0] prod_in;
    logic        prod_cout;
    logic        in_valid;
    logic        out_ready;

    logic        in_ready;
    logic [23:0] acc_out;
    logic        out_valid;
    logic        overflow;
    logic        busy;

    logic        in_ready16;
    logic [15:0] acc_out16;
    logic        out_valid16;
    logic        overflow16;
    logic        busy16;

    int n_checks = 0;
    int n_pass   = 0;

    product_accumulator #(.ACC_W(24), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .prod_in(prod_in), .prod_cout(prod_cout), .in_valid(in_valid),
        .in_ready(in_ready), .acc_out(acc_out), .out_valid(out_valid),
        .out_ready(out_ready), .overflow(overflow), .busy(busy)
    );

    product_accumulator #(.ACC_W(16), .CNT_W(8)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .prod_in(prod_in), .prod_cout(prod_cout), .in_valid(in_valid),
        .in_ready(in_ready16), .acc_out(acc_out16), .out_valid(out_valid16),
        .out_ready(out_ready), .overflow(overflow16), .busy(busy16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_acc"},       longint'(acc_out),   0);
        chk({tag, "_out_valid"}, longint'(out_valid), 0);
        chk({tag, "_overflow"},  longint'(overflow),  0);
        chk({tag, "_busy"},      longint'(busy),      0);
        chk({tag, "_in_ready"},  longint'(in_ready),  0);
        chk({tag, "_acc16"},     longint'(acc_out16), 0);
    endtask

    // Runs one sum; returns at the negedge where the result must be on the outputs.
    task automatic run_sum(input string tag, input int L, input uq_t p, input int maxb,
                           input logic [23:0] e24, input logic ov24,
                           input logic [15:0] e16, input logic ov16, input bit release_res);
        int idx = 0;
        int cyc = 0;
        int bub;
        logic [16:0] pv;
        @(negedge clk);
        start = 1'b1;
        len   = L[7:0];
        @(negedge clk);
        start = 1'b0;
        len   = 8'($urandom);
        bub = (maxb > 0) ? $urandom_range(0, maxb) : 0;
        while (idx < L && cyc < 3000) begin
            if (bub > 0) begin
                in_valid  = 1'b0;
                prod_in   = 16'($urandom);
                prod_cout = 1'($urandom);
                bub--;
            end else begin
                pv        = p[idx][16:0];
                in_valid  = 1'b1;
                {prod_cout, prod_in} = pv;
            end
            if (in_valid && in_ready) begin
                idx++;
                bub = (maxb > 0) ? $urandom_range(0, maxb) : 0;
            end
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_beats"},     idx, L);
        chk({tag, "_out_valid"}, longint'(out_valid), 1);
        chk({tag, "_acc"},       longint'(acc_out), longint'(e24));
        chk({tag, "_overflow"},  longint'(overflow), longint'(ov24));
        chk({tag, "_acc16"},     longint'(acc_out16), longint'(e16));
        chk({tag, "_overflow16"}, longint'(overflow16), longint'(ov16));
        chk({tag, "_in_ready"},  longint'(in_ready), 0);
        chk({tag, "_busy"},      longint'(busy), 1);
        @(negedge clk);
        chk({tag, "_held"}, longint'({out_valid, in_ready, acc_out}), longint'({2'b10, e24}));
        in_valid = 1'b0;
        if (release_res) begin
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            chk({tag, "_released"}, longint'({out_valid, busy}), 0);
        end
    endtask

    vec_t vecs[6];

    initial begin
        uq_t q;
        longint total;
        int L;
        int bad;
        int irdy_seen;

        #200000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        uq_t q;
        longint total;
        int L;
        int bad;
        int irdy_seen;

        vecs[0] = '{"t1_sq4",     4, '{65025, 65025, 65025, 65025}, 0, 24'd260100, 1'b0, 16'd63492, 1'b1};
        vecs[1] = '{"t3_wrap16",  2, '{65025, 65025, 0, 0},         0, 24'd130050, 1'b0, 16'd64514, 1'b1};
        vecs[2] = '{"clear_ovf",  1, '{7, 0, 0, 0},                 0, 24'd7,      1'b0, 16'd7,     1'b0};
        vecs[3] = '{"cout_bit",   2, '{131071, 1, 0, 0},            1, 24'd131072, 1'b0, 16'd0,     1'b1};
        vecs[4] = '{"t2_bubbles", 3, '{1, 2, 3, 0},                 3, 24'd6,      1'b0, 16'd6,     1'b0};
        vecs[5] = '{"max_mix",    4, '{131071, 131071, 131071, 131071}, 2, 24'd524284, 1'b0, 16'd65532, 1'b1};

        rst_n = 1'b0; start = 1'b0; len = '0; prod_in = '0; prod_cout = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            q = {};
            for (int k = 0; k < vecs[i].len; k++) q.push_back(vecs[i].p[k]);
            run_sum(vecs[i].tag, vecs[i].len, q, vecs[i].maxb,
                    vecs[i].e24, vecs[i].ov24, vecs[i].e16, vecs[i].ov16, 1'b1);
        end

        // Zero-length sum: result immediately, input never accepted.
        @(negedge clk);
        start = 1'b1; len = 8'd0; in_valid = 1'b1; prod_in = 16'd99;
        @(negedge clk);
        start = 1'b0;
        chk("t4_out_valid", longint'(out_valid), 1);
        chk("t4_acc", longint'(acc_out), 0);
        chk("t4_acc16", longint'(acc_out16), 0);
        chk("t4_overflow16", longint'(overflow16), 0);
        irdy_seen = 0;
        for (int c = 0; c < 4; c++) begin
            if (in_ready || in_ready16) irdy_seen++;
            @(negedge clk);
        end
        chk("t4_in_ready_never", irdy_seen, 0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b0;
        chk("t4_released", longint'({out_valid, busy}), 0);

        // Stalled consumer: result held, start pulses ignored.
        q = {100, 200};
        run_sum("t5", 2, q, 0, 24'd300, 1'b0, 16'd300, 1'b0, 1'b0);
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            start = c[0]; len = 8'd3;
            @(negedge clk);
            if (acc_out != 24'd300 || out_valid != 1'b1 || in_ready != 1'b0) bad++;
        end
        chk("t5_hold", bad, 0);
        start = 1'b1; len = 8'd3; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0; out_ready = 1'b0;
        chk("t5_idle", longint'({out_valid, busy}), 0);
        chk("t5_acc_kept", longint'(acc_out), 300);
        @(negedge clk);
        chk("t5_start_ignored", longint'({busy, in_ready}), 0);

        // Asynchronous reset in the middle of a sum.
        @(negedge clk);
        start = 1'b1; len = 8'd5;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; prod_in = 16'd1000; prod_cout = 1'b0;
        repeat (2) @(negedge clk);
        chk("t6_busy_before", longint'(busy), 1);
        #2 rst_n = 1'b0;
        #1 chk_zero("t6_async");
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        q = {7};
        run_sum("t6_after", 1, q, 0, 24'd7, 1'b0, 16'd7, 1'b0, 1'b1);

        // Random sums against plain arithmetic.
        for (int r = 0; r < 10; r++) begin
            q = {};
            total = 0;
            L = (r < 2) ? $urandom_range(200, 255) : $urandom_range(1, 30);
            for (int k = 0; k < L; k++) begin
                q.push_back((r < 2) ? $urandom_range(100000, 131071) : $urandom_range(0, 131071));
                total += longint'(q[k]);
            end
            run_sum($sformatf("rand%0d", r), L, q, (r < 2) ? 1 : 3,
                    24'(total % (64'd1 << 24)), (total >= (64'd1 << 24)),
                    16'(total % 65536), (total >= 65536), 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
